// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr
//   Registered N-to-log2(N) request encoder with enable, valid flag,
//   fixed-priority or round-robin arbitration, an accepted-grant counter
//   and a two-digit active-low 7-segment readout of the encoded index.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         encode enable (0 clears y/f at the next edge)
//   mode       0 = fixed priority (highest index wins), 1 = round-robin
//   x[N-1:0]   request vector
//   ack        consumer accepts the grant currently shown on y/f
//   y[W-1:0]   registered encoded index
//   f          registered valid flag
//   gcnt[7:0]  accepted-grant counter (wraps)
//   HEX0/HEX1  active-low segments of y[3:0] / y[7:4], blank when f=0
//
// Handshake: a grant is offered while f=1; it is accepted in any cycle
// where ack=1 and f=1. ack while f=0 is ignored. An accepted grant
// rotates the round-robin pointer for the grant computed at that same
// edge, so a source is never granted twice in a row because of latency.
module prio_encoder_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] x,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         f,
  output logic [7:0]   gcnt,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1
);

  logic [W-1:0] y_q, y_d;
  logic         f_q, f_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [7:0]   gcnt_q, gcnt_d;

  logic         acc;
  logic [W-1:0] eptr;
  logic [W-1:0] fix_idx;
  logic [W-1:0] rr_idx;
  logic [7:0]   y_ext;

  assign acc = ack & f_q;

  // The granted index becomes lowest priority: start the scan one below it.
  // N is a power of two, so W-bit wraparound is the modulo-N step.
  assign eptr = (acc && mode) ? (y_q - W'(1)) : ptr_q;

  // Fixed priority: the last set bit seen in ascending order is the highest.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i]) fix_idx = W'(i);
    end
  end

  // Round-robin: scan downward from eptr, wrapping, first set bit wins.
  always_comb begin
    logic [W-1:0] idx;
    logic         found;
    rr_idx = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = eptr - W'(k);
      if (!found && x[idx]) begin
        rr_idx = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    y_d    = '0;
    f_d    = 1'b0;
    ptr_d  = eptr;
    gcnt_d = acc ? (gcnt_q + 8'd1) : gcnt_q;
    if (en && (|x)) begin
      y_d = mode ? rr_idx : fix_idx;
      f_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      f_q    <= 1'b0;
      ptr_q  <= W'(N - 1);
      gcnt_q <= '0;
    end else begin
      y_q    <= y_d;
      f_q    <= f_d;
      ptr_q  <= ptr_d;
      gcnt_q <= gcnt_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Zero-extend y to two nibbles regardless of W.
  always_comb begin
    y_ext = '0;
    y_ext[W-1:0] = y_q;
  end

  assign HEX0 = f_q ? seg7(y_ext[3:0]) : 7'b1111111;
  // The upper digit carries no information when the index fits in a nibble.
  assign HEX1 = (f_q && (N > 16)) ? seg7(y_ext[7:4]) : 7'b1111111;

  assign y    = y_q;
  assign f    = f_q;
  assign gcnt = gcnt_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
module tb_prio_encoder_rr;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, en8, mode8, ack8;
  logic [7:0] x8;
  logic [2:0] y8;
  logic       f8;
  logic [7:0] gcnt8;
  logic [6:0] hex0_8, hex1_8;

  logic        rst32, en32, mode32, ack32;
  logic [31:0] x32;
  logic [4:0]  y32;
  logic        f32;
  logic [7:0]  gcnt32;
  logic [6:0]  hex0_32, hex1_32;

  prio_encoder_rr #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .mode(mode8), .x(x8), .ack(ack8),
    .y(y8), .f(f8), .gcnt(gcnt8), .HEX0(hex0_8), .HEX1(hex1_8)
  );

  prio_encoder_rr #(.N(32)) dut32 (
    .clk(clk), .rst(rst32), .en(en32), .mode(mode32), .x(x32), .ack(ack32),
    .y(y32), .f(f32), .gcnt(gcnt32), .HEX0(hex0_32), .HEX1(hex1_32)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Integer-level model of the arbitration rules, index 0 = N=8, 1 = N=32.
  int m_y[2], m_f[2], m_ptr[2], m_gcnt[2];

  task automatic model_step(input int d, input bit r, input bit e, input bit m,
                            input logic [31:0] xv, input bit a);
    int n, eptr, pick, idx;
    bit acc;
    n    = (d == 0) ? 8 : 32;
    acc  = a && (m_f[d] != 0);
    eptr = (acc && m) ? (m_y[d] + n - 1) % n : m_ptr[d];
    if (r) begin
      m_y[d] = 0; m_f[d] = 0; m_ptr[d] = n - 1; m_gcnt[d] = 0;
    end else begin
      if (acc) m_gcnt[d] = (m_gcnt[d] + 1) % 256;
      m_ptr[d] = eptr;
      pick = -1;
      if (e) begin
        if (!m) begin
          for (int i = n - 1; i >= 0; i--) if (pick < 0 && xv[i]) pick = i;
        end else begin
          for (int k = 0; k < n; k++) begin
            idx = (eptr - k + n) % n;
            if (pick < 0 && xv[idx]) pick = idx;
          end
        end
      end
      if (pick < 0) begin m_y[d] = 0; m_f[d] = 0; end
      else begin m_y[d] = pick; m_f[d] = 1; end
    end
  endtask

  function automatic logic [6:0] exp_hex(input int yv, input int fv, input int digit, input int n);
    if (fv == 0) return 7'h7F;
    if (digit == 0) return glyph[yv % 16];
    if (n <= 16) return 7'h7F;
    return glyph[(yv / 16) % 16];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step(0, rst8, en8, mode8, {24'b0, x8}, ack8);
    model_step(1, rst32, en32, mode32, x32, ack32);
    #1;
  endtask

  task automatic check_model(input int d);
    if (d == 0) begin
      chk("rand8_y", 32'(y8), 32'(m_y[0]));
      chk("rand8_f", 32'(f8), 32'(m_f[0]));
      chk("rand8_gcnt", 32'(gcnt8), 32'(m_gcnt[0]));
      chk("rand8_hex0", 32'(hex0_8), 32'(exp_hex(m_y[0], m_f[0], 0, 8)));
      chk("rand8_hex1", 32'(hex1_8), 32'(exp_hex(m_y[0], m_f[0], 1, 8)));
    end else begin
      chk("rand32_y", 32'(y32), 32'(m_y[1]));
      chk("rand32_f", 32'(f32), 32'(m_f[1]));
      chk("rand32_gcnt", 32'(gcnt32), 32'(m_gcnt[1]));
      chk("rand32_hex0", 32'(hex0_32), 32'(exp_hex(m_y[1], m_f[1], 0, 32)));
      chk("rand32_hex1", 32'(hex1_32), 32'(exp_hex(m_y[1], m_f[1], 1, 32)));
    end
  endtask

  // ---------------- directed vector table (N=8) ----------------
  typedef struct {
    bit         rst;
    bit         en;
    bit         mode;
    logic [7:0] x;
    bit         ack;
    int         y;
    int         f;
    int         g;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst8 = 1; en8 = 1; mode8 = 0; x8 = 8'hFF; ack8 = 0;
    rst32 = 1; en32 = 0; mode32 = 0; x32 = '0; ack32 = 0;
    for (int d = 0; d < 2; d++) begin
      m_y[d] = 0; m_f[d] = 0; m_ptr[d] = 0; m_gcnt[d] = 0;
    end

    //                rst en md x          ack  y  f  gcnt
    // reset held two cycles, then fixed-priority grant of 0xFF
    tbl.push_back('{1, 1, 0, 8'hFF,      0,   0, 0, 0});
    tbl.push_back('{1, 1, 0, 8'hFF,      0,   0, 0, 0});
    tbl.push_back('{0, 1, 0, 8'hFF,      0,   7, 1, 0});
    // fixed priority; ack in mode 0 counts but does not change y
    tbl.push_back('{0, 1, 0, 8'b00100110, 0,  5, 1, 0});
    tbl.push_back('{0, 1, 0, 8'b00100110, 1,  5, 1, 1});
    tbl.push_back('{0, 1, 0, 8'b00100110, 1,  5, 1, 2});
    // enable low / empty request; ack with f=0 ignored
    tbl.push_back('{0, 0, 0, 8'hFF,      0,   0, 0, 2});
    tbl.push_back('{0, 0, 0, 8'hFF,      1,   0, 0, 2});
    tbl.push_back('{0, 1, 0, 8'h00,      1,   0, 0, 2});
    tbl.push_back('{0, 1, 0, 8'h00,      1,   0, 0, 2});
    // round-robin rotation with all requests and continuous ack
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   7, 1, 2});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   6, 1, 3});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   5, 1, 4});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   4, 1, 5});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   3, 1, 6});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   2, 1, 7});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   1, 1, 8});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   0, 1, 9});
    tbl.push_back('{0, 1, 1, 8'hFF,      1,   7, 1, 10});
    // sparse RR alternation, mode switch, mode back, reset mid-sequence
    tbl.push_back('{0, 1, 1, 8'h81,      1,   0, 1, 11});
    tbl.push_back('{0, 1, 1, 8'h81,      1,   7, 1, 12});
    tbl.push_back('{0, 1, 1, 8'h81,      1,   0, 1, 13});
    tbl.push_back('{0, 1, 1, 8'h81,      1,   7, 1, 14});
    tbl.push_back('{0, 1, 0, 8'h81,      1,   7, 1, 15});
    tbl.push_back('{0, 1, 0, 8'h81,      1,   7, 1, 16});
    tbl.push_back('{0, 1, 1, 8'h81,      1,   0, 1, 17});
    tbl.push_back('{1, 1, 1, 8'h81,      1,   0, 0, 0});
    tbl.push_back('{0, 1, 1, 8'h81,      1,   7, 1, 0});
    tbl.push_back('{0, 1, 1, 8'h81,      1,   0, 1, 1});

    for (int i = 0; i < tbl.size(); i++) begin
      rst8 = tbl[i].rst; en8 = tbl[i].en; mode8 = tbl[i].mode;
      x8 = tbl[i].x; ack8 = tbl[i].ack;
      tick();
      chk($sformatf("vec%0d_y", i), 32'(y8), 32'(tbl[i].y));
      chk($sformatf("vec%0d_f", i), 32'(f8), 32'(tbl[i].f));
      chk($sformatf("vec%0d_gcnt", i), 32'(gcnt8), 32'(tbl[i].g));
      chk($sformatf("vec%0d_hex0", i), 32'(hex0_8),
          32'(tbl[i].f != 0 ? glyph[tbl[i].y] : 7'h7F));
      chk($sformatf("vec%0d_hex1", i), 32'(hex1_8), 32'h7F);
    end

    // ---------------- wide N=32 sequence ----------------
    rst32 = 0; en32 = 1; mode32 = 0; x32 = 32'h1 << 26; ack32 = 0;
    tick();
    chk("wide_y", 32'(y32), 32'd26);
    chk("wide_f", 32'(f32), 32'd1);
    chk("wide_hex0", 32'(hex0_32), 32'(7'b0001000));
    chk("wide_hex1", 32'(hex1_32), 32'(7'b1111001));
    chk("wide_gcnt0", 32'(gcnt32), 32'd0);
    ack32 = 1;
    for (int i = 0; i < 256; i++) begin
      tick();
      chk("wide_gcnt_step", 32'(gcnt32), 32'(m_gcnt[1]));
      if (i == 254) chk("wide_gcnt_255", 32'(gcnt32), 32'd255);
    end
    chk("wide_gcnt_wrap", 32'(gcnt32), 32'd0);
    chk("wide_y_hold", 32'(y32), 32'd26);

    // ---------------- randomized phase vs. model ----------------
    for (int c = 0; c < 1500; c++) begin
      rst8  = ($urandom_range(0, 99) == 0);
      rst32 = ($urandom_range(0, 99) == 0);
      en8   = ($urandom_range(0, 9) != 0);
      en32  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode8  = ~mode8;
      if ($urandom_range(0, 15) == 0) mode32 = ~mode32;
      ack8  = $urandom_range(0, 1);
      ack32 = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: x8 = 8'h00;
        1: x8 = 8'h1 << $urandom_range(0, 7);
        2: x8 = 8'($urandom);
        default: x8 = 8'hFF;
      endcase
      case ($urandom_range(0, 3))
        0: x32 = 32'h0;
        1: x32 = 32'h1 << $urandom_range(0, 31);
        2: x32 = $urandom & $urandom;
        default: x32 = $urandom;
      endcase
      tick();
      check_model(0);
      check_model(1);
    end

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
